// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// FSM state encodings and the halfword alignment helper used for fill addresses.
package icache_pkg;

  localparam int IC_IDX_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_WAIT = 2'd1,
    IC_DROP = 2'd2
  } ic_state_e;

  // Entries are keyed by halfword address; bit 0 of a fetch PC carries no meaning.
  function automatic logic [31:0] hw_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFE;
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The slave modport is the cache; the master modport is its environment.
interface icache_if;

  // Fetch: fetch_valid/fetch_pc are held stable until hit=1 or a flush; hit is the
  // combinational acceptance. Memory: mc_valid/mc_addr are held until a one-cycle
  // mc_done pulse, in which mc_data carries the four bytes at mc_addr.
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        hit;
  logic [31:0] hit_inst;
  logic        mc_valid;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_data;

  modport master (
    output fetch_valid, fetch_pc, mc_done, mc_data,
    input  hit, hit_inst, mc_valid, mc_addr
  );

  modport slave (
    input  fetch_valid, fetch_pc, mc_done, mc_data,
    output hit, hit_inst, mc_valid, mc_addr
  );

endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with zero-latency hits and a single outstanding
// 4-byte refill; each entry holds the 32 bits starting at a halfword-aligned PC.
module icache
  import icache_pkg::*;
#(
  parameter int IDX_WIDTH = IC_IDX_WIDTH_DEF
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      rob_clear,
  icache_if.slave   bus,
  output ic_state_e dbg_state
);

  localparam int ENTRIES = 1 << IDX_WIDTH;
  localparam int TAG_W   = 31 - IDX_WIDTH;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [31:0]        data_q [ENTRIES];

  ic_state_e            state_q, state_d;
  logic                 mc_valid_q, mc_valid_d;
  logic [31:0]          mc_addr_q, mc_addr_d;
  logic [IDX_WIDTH-1:0] req_idx_q, req_idx_d;
  logic [TAG_W-1:0]     req_tag_q, req_tag_d;
  logic                 fill_en;

  logic [IDX_WIDTH-1:0] pc_idx;
  logic [TAG_W-1:0]     pc_tag;
  logic                 lookup_hit;

  assign pc_idx = bus.fetch_pc[IDX_WIDTH:1];
  assign pc_tag = bus.fetch_pc[31:IDX_WIDTH+1];

  // Lookups only happen in IDLE, so a fill never races a hit on the same entry.
  assign lookup_hit = bus.fetch_valid && !rob_clear && (state_q == IC_IDLE) &&
                      valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  assign bus.hit      = lookup_hit;
  assign bus.hit_inst = data_q[pc_idx];
  assign bus.mc_valid = mc_valid_q;
  assign bus.mc_addr  = mc_addr_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d    = state_q;
    mc_valid_d = mc_valid_q;
    mc_addr_d  = mc_addr_q;
    req_idx_d  = req_idx_q;
    req_tag_d  = req_tag_q;
    fill_en    = 1'b0;
    case (state_q)
      IC_IDLE: begin
        if (bus.fetch_valid && !rob_clear && !lookup_hit) begin
          mc_valid_d = 1'b1;
          mc_addr_d  = hw_align(bus.fetch_pc);
          req_idx_d  = pc_idx;
          req_tag_d  = pc_tag;
          state_d    = IC_WAIT;
        end
      end
      IC_WAIT: begin
        if (bus.mc_done) begin
          fill_en    = 1'b1;
          mc_valid_d = 1'b0;
          state_d    = IC_IDLE;
        end else if (rob_clear) begin
          // The controller must see the request through, so mc_valid stays high.
          state_d = IC_DROP;
        end
      end
      IC_DROP: begin
        // Returned data is still correct for its address, so the entry is kept.
        if (bus.mc_done) begin
          fill_en    = 1'b1;
          mc_valid_d = 1'b0;
          state_d    = IC_IDLE;
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IC_IDLE;
      mc_valid_q <= 1'b0;
      mc_addr_q  <= '0;
      req_idx_q  <= '0;
      req_tag_q  <= '0;
      valid_q    <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      mc_valid_q <= mc_valid_d;
      mc_addr_q  <= mc_addr_d;
      req_idx_q  <= req_idx_d;
      req_tag_q  <= req_tag_d;
      if (fill_en) valid_q[req_idx_q] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_en) begin
      tag_q[req_idx_q]  <= req_tag_q;
      data_q[req_idx_q] <= bus.mc_data;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus randomized fetches, checked against a
// model that stores whole halfword addresses and the words filled for them.
module tb_icache;
  import icache_pkg::*;

  localparam int IDX_W = 6;
  localparam int ENT   = 1 << IDX_W;

  logic      clk_in = 1'b0;
  logic      rst_in;
  logic      rdy_in;
  logic      rob_clear;
  ic_state_e dbg_state;

  icache_if bus ();

  icache #(.IDX_WIDTH(IDX_W)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .rob_clear(rob_clear),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: which halfword address each slot holds, and its word
  bit          m_valid [ENT];
  logic [30:0] m_hw    [ENT];
  logic [31:0] m_data  [ENT];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 1) % ENT);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[slot_of(pc)] && (m_hw[slot_of(pc)] == pc[31:1]);
  endfunction

  function automatic void model_fill(input logic [31:0] pc, input logic [31:0] data);
    m_valid[slot_of(pc)] = 1'b1;
    m_hw[slot_of(pc)]    = pc[31:1];
    m_data[slot_of(pc)]  = data;
  endfunction

  function automatic void model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver: one fetch, serviced by a memory controller model if the model predicts a miss
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                          input bit stalls, input bit drop_fv);
    bit          exp_hit;
    logic [31:0] a;
    @(negedge clk_in);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    bus.mc_done     = 1'b0;
    rob_clear       = 1'b0;
    rdy_in          = 1'b1;
    #1;
    exp_hit = model_hit(pc);
    check("lookup_hit", bus.hit, exp_hit);
    if (exp_hit) begin
      check("hit_inst", bus.hit_inst, m_data[slot_of(pc)]);
      @(negedge clk_in); #1;
      check("no_req_on_hit", bus.mc_valid, 0);
    end else begin
      exp_q.push_back(pc & 32'hFFFF_FFFE);
      @(negedge clk_in);
      if (drop_fv) bus.fetch_valid = 1'b0;
      #1;
      check("mc_valid_issue", bus.mc_valid, 1);
      check("state_wait", dbg_state, IC_WAIT);
      a = exp_q.pop_front();
      check("mc_addr", bus.mc_addr, a);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk_in);
        rdy_in = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        check("hit_in_wait", bus.hit, 0);
        check("mc_valid_held", bus.mc_valid, 1);
      end
      @(negedge clk_in);
      rdy_in      = 1'b1;
      bus.mc_done = 1'b1;
      bus.mc_data = data;
      #1;
      check("hit_at_done", bus.hit, 0);
      @(negedge clk_in);
      bus.mc_done = 1'b0;
      #1;
      model_fill(pc, data);
      check("fill_hit", bus.hit, {31'b0, !drop_fv});
      if (!drop_fv) check("fill_inst", bus.hit_inst, data);
      check("mc_valid_clear", bus.mc_valid, 0);
    end
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] d;
    rst_in          = 1'b0;
    rdy_in          = 1'b1;
    rob_clear       = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h0;
    bus.mc_done     = 1'b0;
    bus.mc_data     = 32'h0;
    model_reset();
    repeat (3) @(negedge clk_in);
    #1;
    check("rst_hit", bus.hit, 0);
    check("rst_mc_valid", bus.mc_valid, 0);
    check("rst_mc_addr", bus.mc_addr, 0);
    check("rst_state", dbg_state, IC_IDLE);
    @(negedge clk_in);
    rst_in          = 1'b1;
    bus.fetch_valid = 1'b0;

    // cold miss, warm hit, conflict eviction, halfword-aligned fill
    do_fetch(32'h0000_0000, 32'h0000_0513, 1'b0, 1'b0);
    do_fetch(32'h0000_0000, 32'h0000_0513, 1'b0, 1'b0);
    do_fetch(32'h0000_0080, mem_word(32'h80), 1'b0, 1'b0);
    do_fetch(32'h0000_0000, 32'h0000_0513, 1'b0, 1'b0);
    do_fetch(32'h0000_0102, 32'h4505_0001, 1'b0, 1'b0);
    do_fetch(32'h0000_0103, 32'h4505_0001, 1'b0, 1'b0);

    // flush mid-miss, with a stalled cycle in between
    pc = 32'h0000_4006;
    d  = mem_word(pc);
    @(negedge clk_in); bus.fetch_valid = 1'b1; bus.fetch_pc = pc; #1;
    check("flush_first_lookup", bus.hit, 0);
    @(negedge clk_in); #1;
    check("flush_wait", dbg_state, IC_WAIT);
    @(negedge clk_in); rdy_in = 1'b0; rob_clear = 1'b1; #1;
    check("flush_hit_clear", bus.hit, 0);
    @(negedge clk_in); rdy_in = 1'b1; #1;
    check("stall_hold_state", dbg_state, IC_WAIT);
    @(negedge clk_in); rob_clear = 1'b0; #1;
    check("drop_state", dbg_state, IC_DROP);
    check("drop_mc_valid", bus.mc_valid, 1);
    @(negedge clk_in); #1;
    check("drop_no_hit", bus.hit, 0);
    @(negedge clk_in); bus.mc_done = 1'b1; bus.mc_data = d; #1;
    check("drop_done_no_hit", bus.hit, 0);
    @(negedge clk_in); bus.mc_done = 1'b0; bus.fetch_valid = 1'b0; #1;
    check("drop_back_idle", dbg_state, IC_IDLE);
    check("drop_mc_clear", bus.mc_valid, 0);
    model_fill(pc, d);
    do_fetch(pc, d, 1'b0, 1'b0);

    // flush and completion in the same cycle
    pc = 32'h0000_8010;
    d  = mem_word(pc);
    @(negedge clk_in); bus.fetch_valid = 1'b1; bus.fetch_pc = pc; #1;
    @(negedge clk_in); #1;
    check("sim_wait", dbg_state, IC_WAIT);
    @(negedge clk_in); rob_clear = 1'b1; bus.mc_done = 1'b1; bus.mc_data = d; #1;
    check("sim_hit_suppressed", bus.hit, 0);
    @(negedge clk_in); rob_clear = 1'b0; bus.mc_done = 1'b0; #1;
    model_fill(pc, d);
    check("sim_idle", dbg_state, IC_IDLE);
    check("sim_hit_after", bus.hit, 1);
    check("sim_inst", bus.hit_inst, d);

    // flush while idle issues nothing
    @(negedge clk_in); bus.fetch_pc = 32'h0000_C020; rob_clear = 1'b1; #1;
    check("idle_clear_hit", bus.hit, 0);
    @(negedge clk_in); #1;
    check("idle_clear_no_req", bus.mc_valid, 0);
    check("idle_clear_state", dbg_state, IC_IDLE);
    @(negedge clk_in); rob_clear = 1'b0; bus.fetch_valid = 1'b0;

    // randomized fetches with stalls and abandoned requests
    for (int i = 0; i < 200; i++) begin
      pc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 63)) << 1) |
           32'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) pc[31:20] = 12'($urandom);
      do_fetch(pc, mem_word(pc & 32'hFFFF_FFFE), 1'b1, $urandom_range(0, 3) == 0);
    end

    // async reset in the middle of a refill
    @(negedge clk_in); bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0000_0200; rdy_in = 1'b1;
    #1;
    if (!model_hit(32'h0000_0200)) begin
      @(negedge clk_in); #1;
      check("arst_pre_mc_valid", bus.mc_valid, 1);
    end
    #2;
    rst_in = 1'b0;
    #1;
    model_reset();
    check("arst_mc_valid", bus.mc_valid, 0);
    check("arst_mc_addr", bus.mc_addr, 0);
    check("arst_state", dbg_state, IC_IDLE);
    bus.fetch_pc = 32'h0000_0000;
    #1;
    check("arst_lookup_0", bus.hit, 0);
    bus.fetch_pc = 32'h0000_0102;
    #1;
    check("arst_lookup_102", bus.hit, 0);
    @(negedge clk_in); rst_in = 1'b1; bus.fetch_valid = 1'b0;
    do_fetch(32'h0000_0000, 32'h0000_0513, 1'b0, 1'b0);
    do_fetch(32'h0000_0000, 32'h0000_0513, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
